// File: rtl/rr_grant_arb_pkg.sv
// rtl/rr_grant_arb_pkg.sv - shared state encoding and id-width helper for rr_grant_arb
package rr_grant_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int HOLD_W = 8;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder: first set r bit scanning ptr, ptr+1, ... mod N
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  r,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [IW:0] sum;

   // Walk from the farthest offset down so the nearest request to ptr wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      sum   = '0;
      for (int j = N - 1; j >= 0; j--) begin
         sum = {1'b0, ptr} + (IW + 1)'(j);
         if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
         end
         if (r[sum[IW-1:0]]) begin
            valid = 1'b1;
            idx   = sum[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_grant_arb.sv
// rtl/rr_grant_arb.sv - round-robin grant arbiter with one-cycle release gap
// Optional hold-limit timeout enabled by macro RR_GRANT_ARB_TIMEOUT_EN.
module rr_grant_arb
   import rr_grant_arb_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IW       = id_width(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  r,
   output logic [N-1:0]  g,
   output logic [IW-1:0] gid,
`ifdef RR_GRANT_ARB_TIMEOUT_EN
   output logic          timeout,
`endif
   output logic          busy
);

   state_t      state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW:0]   next_ptr;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q, timeout_d;
`endif

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .r     (r),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      next_ptr = {1'b0, owner_q} + (IW + 1)'(1);
      if (next_ptr == (IW + 1)'(N)) begin
         next_ptr = '0;
      end
`ifdef RR_GRANT_ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE, GAP: begin
            if (pick_valid) begin
               state_d = GRANT;
               owner_d = pick_idx;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
               hold_d  = '0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!r[owner_q]) begin
               state_d = GAP;
               ptr_d   = next_ptr[IW-1:0];
            end
`ifdef RR_GRANT_ARB_TIMEOUT_EN
            // hold_q counts completed grant cycles minus one.
            else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
               state_d   = GAP;
               ptr_d     = next_ptr[IW-1:0];
               timeout_d = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
         hold_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
`ifdef RR_GRANT_ARB_TIMEOUT_EN
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      g = '0;
      for (int k = 0; k < N; k++) begin
         g[k] = (state_q == GRANT) && (owner_q == IW'(k));
      end
      gid  = (state_q == GRANT) ? owner_q : '0;
      busy = (state_q == GRANT);
   end

`ifdef RR_GRANT_ARB_TIMEOUT_EN
   assign timeout = timeout_q;
`endif

endmodule

// File: doc/rr_grant_arb.md
RR_GRANT_ARB -- requirements
Module: rr_grant_arb

Interface
REQ-001 Parameter N, default 4, number of requesters; legal range 2..8, any value, not restricted to powers of two.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner; legal range 2..255; used only when RR_GRANT_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 r  input  N  request vector; bit k high = requester k wants the resource.
REQ-006 g  output  N  one-hot-or-zero grant vector, decoded combinationally from registered state only.
REQ-007 gid  output  max(1,$clog2(N))  index of current owner; 0 when no grant.
REQ-008 busy  output  1  high exactly when g != 0.
REQ-009 timeout  output  1  one-cycle pulse on forced release; present only when RR_GRANT_ARB_TIMEOUT_EN is defined.

Function
REQ-010 State machine SHALL have states IDLE (no grant), GRANT (one owner), GAP (one dead cycle, no grant).
REQ-011 Arbitration in IDLE or GAP SHALL select the first asserted r bit scanning ptr, ptr+1, ... wrapping modulo N; none asserted -> IDLE.
REQ-012 Grant latency SHALL be one cycle: r sampled at edge t -> g high after edge t (visible during cycle t+1), never combinationally from r.
REQ-013 In GRANT with owner k, r[k]=1 SHALL hold the grant; r[k]=0 SHALL move to GAP and set ptr to (k+1) mod N.
REQ-014 GAP SHALL last exactly one cycle with g=0, then arbitrate per REQ-011 (grant on next edge or IDLE).
REQ-015 Requests from non-owners during GRANT SHALL be ignored; no preemption.
REQ-016 ptr SHALL change only on release; wrap from N-1 to 0.
REQ-017 g SHALL never have more than one bit set; gid SHALL equal the set bit's index.
REQ-018 Single requester k continuously requesting after release SHALL be regranted after the one GAP cycle (no starvation of sole requester).
REQ-019 Illegal/unreached state encodings SHALL return to IDLE on the next edge with g=0.

Reset
REQ-020 reset=1 at an edge SHALL force state=IDLE, ptr=0, hold counter=0, g=0, gid=0, busy=0, timeout=0; reset has priority over all transitions, including mid-grant.
REQ-021 First arbitration after reset release SHALL start scanning at index 0.

Configuration
REQ-022 Macro RR_GRANT_ARB_TIMEOUT_EN defined: hold counter counts grant cycles; when owner k has held MAX_HOLD cycles and r[k] is still 1, next edge SHALL force GAP, set ptr=(k+1) mod N and pulse timeout for one cycle (the GAP cycle).
REQ-023 Macro undefined: no hold counter, no timeout port; grants held indefinitely while r[k]=1.
REQ-024 Hold counter SHALL clear on every entry to GRANT; normal release on the same edge as limit SHALL count as normal release (timeout=0).

Structure
REQ-025 Package rr_grant_arb_pkg SHALL hold the state enum (IDLE, GRANT, GAP) and the id-width helper constant.
REQ-026 Sub-module rr_pick (combinational rotating priority encoder: r, ptr -> valid, index) SHALL be instantiated once.

Verification (N=4, MAX_HOLD=8)
REQ-027 After reset, r=4'b0110 -> g=4'b0010, gid=1 one cycle later; drop r[1] -> one GAP cycle g=0 -> g=4'b0100, gid=2.
REQ-028 r=4'b1111 held, each owner drops r after 2 grant cycles then reasserts -> grant order 0,1,2,3,0 with one g=0 cycle between each.
REQ-029 Owner 3 releases with r=4'b0001 -> ptr wraps to 0, g=4'b0001 after GAP.
REQ-030 TIMEOUT_EN defined, r=4'b0011 held constant -> owner 0 for 8 cycles, timeout=1 for 1 cycle, then owner 1 for 8 cycles; undefined -> owner 0 indefinitely.
REQ-031 reset pulsed while g=4'b0100 -> g=0 on the next cycle; with r=4'b1100 after release -> g=4'b0100 (scan from 0).
REQ-032 Every cycle of every test: assert $onehot0(g), busy==|g, gid matches g.
